// File: rtl/fxp_pkg.sv
// Shared fixed-point helpers for the DSP datapath arithmetic blocks.
// Holds the rounding-mode encodings and the common clamp-to-width function.
package fxp_pkg;

    localparam logic RND_TRUNC   = 1'b0;
    localparam logic RND_HALF_UP = 1'b1;

    localparam int FXP_MAX_W = 64;

    typedef struct packed {
        logic signed [FXP_MAX_W-1:0] value;
        logic                        ovf;
        logic                        unf;
    } fxp_sat_t;

    // Clamp a sign-extended value into a signed field of 'width' bits.
    function automatic fxp_sat_t fxp_sat(input logic signed [FXP_MAX_W-1:0] value,
                                         input int                          width);
        fxp_sat_t                    res;
        logic signed [FXP_MAX_W-1:0] v_max;
        logic signed [FXP_MAX_W-1:0] v_min;
        v_max     = (64'sd1 <<< (width - 1)) - 64'sd1;
        v_min     = -(64'sd1 <<< (width - 1));
        res.value = value;
        res.ovf   = 1'b0;
        res.unf   = 1'b0;
        if (value > v_max) begin
            res.value = v_max;
            res.ovf   = 1'b1;
        end else if (value < v_min) begin
            res.value = v_min;
            res.unf   = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational rounding and saturation of a full-precision product
// into the output Q format; feeds the final pipeline register.
module fxp_round_sat
    import fxp_pkg::*;
#(
    parameter int WI1 = 6,
    parameter int WF1 = 10,
    parameter int WI2 = 6,
    parameter int WF2 = 8,
    parameter int WIO = 6,
    parameter int WFO = 8
) (
    input  logic signed [WI1+WF1+WI2+WF2-1:0] i_prod,
    input  logic                              i_rnd,
    output logic signed [WIO+WFO-1:0]         o_c,
    output logic                              o_ovf,
    output logic                              o_unf
);

    localparam int PW = WI1 + WF1 + WI2 + WF2;
    localparam int OW = WIO + WFO;
    localparam int SH = WF1 + WF2 - WFO;
    localparam int RW = PW + 1 - SH;

    localparam logic signed [PW:0] HALF = (PW+1)'(1) << (SH - 1);

    generate
        if (WFO < 1 || WFO >= WF1 + WF2) begin : g_bad_wfo
            $error("fxp_round_sat: WFO must satisfy 1 <= WFO < WF1+WF2");
        end
    endgenerate

    // One guard bit above the product keeps the half-up bias from wrapping.
    function automatic logic signed [RW-1:0] round_shift(input logic signed [PW-1:0] p,
                                                         input logic              rnd);
        logic signed [PW:0] sum;
        sum = {p[PW-1], p};
        if (rnd == RND_HALF_UP) begin
            sum = sum + HALF;
        end
        return RW'(sum >>> SH);
    endfunction

    logic signed [RW-1:0] w_r;
    fxp_sat_t             w_sat;

    always_comb begin
        w_r   = round_shift(i_prod, i_rnd);
        w_sat = fxp_sat(FXP_MAX_W'(w_r), OW);
        o_c   = OW'(w_sat.value);
        o_ovf = w_sat.ovf;
        o_unf = w_sat.unf;
    end

endmodule

// File: rtl/fxp_mul_pipe.sv
// Three-stage signed fixed-point multiplier with valid/ready streaming,
// per-sample saturation flags, sticky flags and a saturating event counter.
module fxp_mul_pipe
    import fxp_pkg::*;
#(
    parameter int WI1   = 6,
    parameter int WF1   = 10,
    parameter int WI2   = 6,
    parameter int WF2   = 8,
    parameter int WIO   = 6,
    parameter int WFO   = 8,
    parameter int CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [WI1+WF1-1:0] A,
    input  logic signed [WI2+WF2-1:0] B,
    input  logic                      rnd,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [WIO+WFO-1:0] C,
    output logic                      overflow,
    output logic                      underflow,
    output logic                      ovf_sticky,
    output logic                      unf_sticky,
    output logic [CNT_W-1:0]          sat_count,
    input  logic                      clr_flags
);

    localparam int AW = WI1 + WF1;
    localparam int BW = WI2 + WF2;
    localparam int PW = AW + BW;
    localparam int OW = WIO + WFO;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                 w_en;
    logic                 w_xfer;
    logic                 w_sat_evt;

    logic                 r_vld_p1;
    logic                 r_vld_p2;
    logic                 r_vld_p3;

    logic signed [AW-1:0] r_a_p1;
    logic signed [BW-1:0] r_b_p1;
    logic                 r_rnd_p1;

    logic signed [PW-1:0] r_prod_p2;
    logic                 r_rnd_p2;

    logic signed [OW-1:0] w_c;
    logic                 w_ovf;
    logic                 w_unf;

    logic signed [OW-1:0] r_c_p3;
    logic                 r_ovf_p3;
    logic                 r_unf_p3;

    logic                 r_ovf_sticky;
    logic                 r_unf_sticky;
    logic [CNT_W-1:0]     r_sat_cnt;

    // The whole pipe moves as one; bubbles stay where they are.
    assign w_en     = ~r_vld_p3 | out_ready;
    assign in_ready = w_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_vld_p3 <= 1'b0;
        end else if (w_en) begin
            r_vld_p1 <= in_valid;
            r_vld_p2 <= r_vld_p1;
            r_vld_p3 <= r_vld_p2;
        end
    end

    // S1: operand capture
    always_ff @(posedge clk) begin
        if (w_en) begin
            r_a_p1   <= A;
            r_b_p1   <= B;
            r_rnd_p1 <= rnd;
        end
    end

    // S2: full-precision product
    always_ff @(posedge clk) begin
        if (w_en) begin
            r_prod_p2 <= PW'(r_a_p1) * PW'(r_b_p1);
            r_rnd_p2  <= r_rnd_p1;
        end
    end

    fxp_round_sat #(
        .WI1 (WI1),
        .WF1 (WF1),
        .WI2 (WI2),
        .WF2 (WF2),
        .WIO (WIO),
        .WFO (WFO)
    ) u_round_sat (
        .i_prod (r_prod_p2),
        .i_rnd  (r_rnd_p2),
        .o_c    (w_c),
        .o_ovf  (w_ovf),
        .o_unf  (w_unf)
    );

    // S3: rounded, saturated result; only real samples overwrite it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_c_p3   <= '0;
            r_ovf_p3 <= 1'b0;
            r_unf_p3 <= 1'b0;
        end else if (w_en && r_vld_p2) begin
            r_c_p3   <= w_c;
            r_ovf_p3 <= w_ovf;
            r_unf_p3 <= w_unf;
        end
    end

    assign w_xfer    = r_vld_p3 & out_ready;
    assign w_sat_evt = w_xfer & (r_ovf_p3 | r_unf_p3);

    // A saturating transfer beats a simultaneous clear so no event is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf_sticky <= 1'b0;
            r_unf_sticky <= 1'b0;
            r_sat_cnt    <= '0;
        end else begin
            if (w_xfer && r_ovf_p3) begin
                r_ovf_sticky <= 1'b1;
            end else if (clr_flags) begin
                r_ovf_sticky <= 1'b0;
            end
            if (w_xfer && r_unf_p3) begin
                r_unf_sticky <= 1'b1;
            end else if (clr_flags) begin
                r_unf_sticky <= 1'b0;
            end
            if (clr_flags) begin
                r_sat_cnt <= w_sat_evt ? CNT_W'(1) : '0;
            end else if (w_sat_evt && r_sat_cnt != CNT_MAX) begin
                r_sat_cnt <= r_sat_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid  = r_vld_p3;
    assign C          = r_c_p3;
    assign overflow   = r_ovf_p3 & r_vld_p3;
    assign underflow  = r_unf_p3 & r_vld_p3;
    assign ovf_sticky = r_ovf_sticky;
    assign unf_sticky = r_unf_sticky;
    assign sat_count  = r_sat_cnt;

endmodule

// File: tb/tb_fxp_mul_pipe.sv
// Scoreboard bench for fxp_mul_pipe: directed corner cases plus a randomized
// stream, checked against an integer-arithmetic reference model.
module tb_fxp_mul_pipe;
    import fxp_pkg::*;

    localparam int       SH   = 10;
    localparam longint   CMAX = 8191;
    localparam longint   CMIN = -8192;

    typedef struct {
        logic [13:0] c;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [13:0] B;
    logic        rnd;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] C;
    logic        overflow;
    logic        underflow;
    logic        ovf_sticky;
    logic        unf_sticky;
    logic [7:0]  sat_count;
    logic        clr_flags;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          rdy_mode = 1;
    bit          mon_en   = 0;

    logic        m_ovf = 0;
    logic        m_unf = 0;
    int          m_cnt = 0;

    logic [15:0] sa[5];
    logic [13:0] sb[5];
    int          s_idx;
    logic [13:0] c_hold;

    fxp_mul_pipe dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .rnd        (rnd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .C          (C),
        .overflow   (overflow),
        .underflow  (underflow),
        .ovf_sticky (ovf_sticky),
        .unf_sticky (unf_sticky),
        .sat_count  (sat_count),
        .clr_flags  (clr_flags)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "timeout");
    end

    // Reference: exact product, floor division by 2^SH, then clamp.
    function automatic exp_t model(input logic [15:0] a, input logic [13:0] b, input logic r);
        exp_t   e;
        longint p, num, den, q;
        p   = longint'($signed(a)) * longint'($signed(b));
        den = longint'(1) << SH;
        num = p + (r ? (den / 2) : 0);
        q   = num / den;
        if ((num % den) != 0 && num < 0) q = q - 1;
        e.ovf = 0;
        e.unf = 0;
        if (q > CMAX) begin
            q = CMAX; e.ovf = 1;
        end else if (q < CMIN) begin
            q = CMIN; e.unf = 1;
        end
        e.c = q[13:0];
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered at posedge+1; leaves at posedge+1 after the accepting edge.
    task automatic send(input logic [15:0] a, input logic [13:0] b, input logic r);
        int n;
        n = 0;
        A = a; B = b; rnd = r; in_valid = 1;
        #1;
        while (!in_ready && n < 300) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("in_ready_wait", in_ready, 1);
        if (in_ready) sb_q.push_back(model(a, b, r));
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic stream_run(input int max_cyc);
        for (int c = 0; c < max_cyc && s_idx < 5; c++) begin
            A = sa[s_idx]; B = sb[s_idx]; rnd = RND_TRUNC; in_valid = 1;
            #1;
            if (in_ready) begin
                sb_q.push_back(model(sa[s_idx], sb[s_idx], RND_TRUNC));
                s_idx++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", sb_q.size(), 0);
        tick();
    endtask

    task automatic check_latency(input string name);
        @(negedge clk); check({name, "_c1"}, out_valid, 0);
        @(negedge clk); check({name, "_c2"}, out_valid, 0);
        @(negedge clk); check({name, "_c3"}, out_valid, 1);
    endtask

    initial begin
        out_ready = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 0;
                1: out_ready = 1;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        logic xfer;
        logic got;
        if (mon_en) begin
            check("ovf_sticky", ovf_sticky, m_ovf);
            check("unf_sticky", unf_sticky, m_unf);
            check("sat_count", sat_count, m_cnt);
            if (!out_valid) check("flags_idle", {overflow, underflow}, 0);
            if (reset) begin
                m_ovf = 0; m_unf = 0; m_cnt = 0;
            end else begin
                xfer = out_valid && out_ready;
                got  = 0;
                e    = '{c: 0, ovf: 0, unf: 0};
                if (xfer) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL out_unexpected: C=%h delivered with no sample outstanding", C);
                    end else begin
                        e = sb_q.pop_front();
                        got = 1;
                        check("C", C, e.c);
                        check("overflow", overflow, e.ovf);
                        check("underflow", underflow, e.unf);
                    end
                end
                if (clr_flags) begin
                    m_ovf = got && e.ovf;
                    m_unf = got && e.unf;
                    m_cnt = (got && (e.ovf || e.unf)) ? 1 : 0;
                end else if (got) begin
                    if (e.ovf) m_ovf = 1;
                    if (e.unf) m_unf = 1;
                    if ((e.ovf || e.unf) && m_cnt < 255) m_cnt = m_cnt + 1;
                end
            end
        end
    end

    initial begin
        reset = 1; in_valid = 0; A = 0; B = 0; rnd = 0; clr_flags = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        mon_en = 1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_C", C, 0);
        check("rst_sat_count", sat_count, 0);
        tick();

        // 1.0 x 1.0 and its latency
        send(16'h0400, 14'h0100, RND_TRUNC);
        check_latency("s1_lat");
        check("s1_C", C, 14'h0100);
        tick();

        // LSB rounding on both signs
        send(16'h0001, 14'h0200, RND_TRUNC);
        send(16'h0001, 14'h0200, RND_HALF_UP);
        send(16'hFFFF, 14'h0200, RND_TRUNC);
        send(16'hFFFF, 14'h0200, RND_HALF_UP);
        wait_drain();

        // Saturation both ways
        send(16'h7FFF, 14'h1FFF, RND_TRUNC);
        send(16'h8000, 14'h1FFF, RND_TRUNC);
        wait_drain();
        @(negedge clk);
        check("s3_ovf_sticky", ovf_sticky, 1);
        check("s3_unf_sticky", unf_sticky, 1);
        check("s3_sat_count", sat_count, 2);
        tick();

        // Back-pressure with a 5-deep stream
        rdy_mode = 0;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            sa[i] = 16'($urandom);
            sb[i] = 14'($urandom) >> 4;
        end
        s_idx = 0;
        stream_run(8);
        check("s4_accepted", s_idx, 3);
        @(negedge clk);
        check("s4_in_ready", in_ready, 0);
        check("s4_out_valid", out_valid, 1);
        c_hold = C;
        repeat (3) @(negedge clk);
        check("s4_C_held", C, c_hold);
        rdy_mode = 1;
        tick();
        stream_run(40);
        check("s4_all_sent", s_idx, 5);
        wait_drain();

        // Clear coinciding with a saturating transfer
        rdy_mode = 0;
        tick(); tick();
        send(16'h7FFF, 14'h1FFF, RND_HALF_UP);
        begin
            int n;
            n = 0;
            while (!out_valid && n < 10) begin
                @(negedge clk);
                n++;
            end
        end
        check("s5_stalled_valid", out_valid, 1);
        rdy_mode = 1;
        tick();
        clr_flags = 1;
        tick();
        clr_flags = 0;
        @(negedge clk);
        check("s5_ovf_sticky", ovf_sticky, 1);
        check("s5_sat_count", sat_count, 1);
        tick();

        // Counter saturation
        for (int i = 0; i < 300; i++) begin
            send((i % 2) ? 16'h8000 : 16'h7FFF, 14'h1FFF, 1'($urandom));
        end
        wait_drain();
        @(negedge clk);
        check("s5_sat_count_max", sat_count, 8'hFF);
        tick();

        // Reset with two samples in flight
        send(16'h0400, 14'h0100, RND_TRUNC);
        send(16'h0800, 14'h0100, RND_TRUNC);
        reset = 1;
        sb_q.delete();
        tick();
        reset = 0;
        @(negedge clk);
        check("s6_out_valid", out_valid, 0);
        check("s6_C", C, 0);
        check("s6_ovf_sticky", ovf_sticky, 0);
        check("s6_unf_sticky", unf_sticky, 0);
        check("s6_sat_count", sat_count, 0);
        tick();
        send(16'h0C00, 14'h0180, RND_TRUNC);
        check_latency("s6_lat");
        check("s6_C_post", C, 14'h0480);
        tick();

        // Randomized stream with random back-pressure, gaps and clears
        rdy_mode = 2;
        for (int i = 0; i < 250; i++) begin
            logic [15:0] a;
            logic [13:0] b;
            a = 16'($urandom);
            b = 14'($urandom);
            if ($urandom_range(0, 1) != 0) a = 16'($signed(a) >>> $urandom_range(3, 12));
            if ($urandom_range(0, 1) != 0) b = 14'($signed(b) >>> $urandom_range(3, 10));
            clr_flags = ($urandom_range(0, 15) == 0);
            send(a, b, 1'($urandom));
            clr_flags = 0;
            repeat ($urandom_range(0, 2)) tick();
        end
        rdy_mode = 1;
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
